// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor a - b - bin, purely combinational (zero latency, no flow control).
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B-Bin, LSB first; done pulses WIDTH+1 cycles after the start is taken, start ignored while busy.
// Optional two's-complement overflow output Ovf under SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_nxt;
  logic             br;
  logic             load, shift, last, finish;
  logic             d_bit, bout;

  fs_cell u_fs_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout)
  );

  // New difference bits enter at the MSB so bit 0 lands in d_sr[0] after WIDTH shifts.
  if (WIDTH == 1) begin : g_w1
    assign d_nxt = d_bit;
  end else begin : g_wn
    assign d_nxt = {d_bit, d_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = (cnt == LAST) ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && start;
    shift  = (state == RUN);
    last   = shift && (cnt == LAST);
    finish = (state == DONE);
    busy   = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (shift) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_nxt;
      br   <= bout;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Results are published from DONE so Diff/Borr only ever change with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      Borr <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        Diff <= d_sr;
        Borr <= br;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;

  // Overflow is borrow-into-MSB xor borrow-out-of-MSB, both visible on the last bit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      if (last)   ovf_q <= br ^ bout;
      if (finish) Ovf   <= ovf_q;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at WIDTH=8 and WIDTH=2 against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       borr8, busy8, done8;
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, diff2;
  logic       borr2, busy2, done2;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf8, ovf2;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Diff(diff8), .Borr(borr8), .busy(busy8), .done(done8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .Ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Bin(bin2),
    .Diff(diff2), .Borr(borr2), .busy(busy2), .done(done2)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .Ovf(ovf2)
`endif
  );

  // Reference model: plain integer arithmetic on W-bit operands.
  function automatic int m_diff(input int w, input int a, input int b, input int bi);
    return (a - b - bi) & ((1 << w) - 1);
  endfunction

  function automatic logic m_borr(input int a, input int b, input int bi);
    return (a < b + bi);
  endfunction

  function automatic logic m_ovf(input int w, input int a, input int b, input int bi);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa - sb - bi;
    return (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
  endfunction

  // Drives one WIDTH=8 operation from IDLE; scrambles operands after capture. lat=0 means timeout.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic br, output logic ov, output int lat);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    d  = diff8;
    br = borr8;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ov = ovf8;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({diff8, borr8, busy8, done8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got diff=%h borr=%b busy=%b done=%b, required all 0", diff8, borr8, busy8, done8);
    end
    checks++;
    if ({diff2, borr2, busy2, done2} !== 5'd0) begin
      errors++;
      $display("FAIL reset2: got diff=%h borr=%b busy=%b done=%b, required all 0", diff2, borr2, busy2, done2);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if ({ovf8, ovf2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ovf: got %b%b, required 00", ovf8, ovf2);
    end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [7:0] va[5] = '{8'h05, 8'h00, 8'h80, 8'hFF, 8'h00};
    logic [7:0] vb[5] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h00};
    logic       vi[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] d;
    logic       br, ov;
    int         lat;
    for (int i = 0; i < 5; i++) begin
      run_op8(va[i], vb[i], vi[i], d, br, ov, lat);
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL vec_latency #%0d: got %0d cycles, required 9", i, lat);
      end
      checks++;
      if (d !== 8'(m_diff(8, va[i], vb[i], vi[i])) || br !== m_borr(va[i], vb[i], vi[i])) begin
        errors++;
        $display("FAIL vec_result #%0d: got diff=%h borr=%b, required diff=%h borr=%b", i, d, br,
                 8'(m_diff(8, va[i], vb[i], vi[i])), m_borr(va[i], vb[i], vi[i]));
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checks++;
      if (ov !== m_ovf(8, va[i], vb[i], vi[i])) begin
        errors++;
        $display("FAIL vec_ovf #%0d: got %b, required %b", i, ov, m_ovf(8, va[i], vb[i], vi[i]));
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== d) begin
        errors++;
        $display("FAIL vec_after_done #%0d: got done=%b busy=%b diff=%h, required 0 0 %h", i, done8, busy8, diff8, d);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d;
    logic       bi, br, ov;
    int         lat;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      run_op8(a, b, bi, d, br, ov, lat);
      checks++;
      if (lat != 9 || d !== 8'(m_diff(8, a, b, bi)) || br !== m_borr(a, b, bi)) begin
        errors++;
        $display("FAIL rand %h-%h-%b: got lat=%0d diff=%h borr=%b, required lat=9 diff=%h borr=%b",
                 a, b, bi, lat, d, br, 8'(m_diff(8, a, b, bi)), m_borr(a, b, bi));
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checks++;
      if (ov !== m_ovf(8, a, b, bi)) begin
        errors++;
        $display("FAIL rand_ovf %h-%h-%b: got %b, required %b", a, b, bi, ov, m_ovf(8, a, b, bi));
      end
`endif
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic       br, ov, seen;
    int         lat;
    run_op8(8'h10, 8'h01, 1'b0, d, br, ov, lat);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (diff8 !== 8'h00 || borr8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got diff=%h borr=%b busy=%b done=%b, required all 0", diff8, borr8, busy8, done8);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got activity=%b after aborted op, required 0", seen);
    end
    run_op8(8'h3C, 8'h0F, 1'b1, d, br, ov, lat);
    checks++;
    if (lat != 9 || d !== 8'h2C || br !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got lat=%0d diff=%h borr=%b, required lat=9 diff=2c borr=0", lat, d, br);
    end
  endtask

  task automatic test_back_to_back_w2();
    logic [4:0] v;
    int         lat;
    start2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      a2 = v[4:3]; b2 = v[2:1]; bin2 = v[0];
      @(posedge clk); #1;
      checks++;
      if (busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL w2_capture #%0d: got busy=%b done=%b, required 1 0", i, busy2, done2);
      end
      a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done2 === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != 3 || diff2 !== 2'(m_diff(2, v[4:3], v[2:1], v[0])) || borr2 !== m_borr(v[4:3], v[2:1], v[0])) begin
        errors++;
        $display("FAIL w2 %0d-%0d-%0d: got lat=%0d diff=%0d borr=%b, required lat=3 diff=%0d borr=%b",
                 v[4:3], v[2:1], v[0], lat, diff2, borr2,
                 m_diff(2, v[4:3], v[2:1], v[0]), m_borr(v[4:3], v[2:1], v[0]));
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checks++;
      if (ovf2 !== m_ovf(2, v[4:3], v[2:1], v[0])) begin
        errors++;
        $display("FAIL w2_ovf #%0d: got %b, required %b", i, ovf2, m_ovf(2, v[4:3], v[2:1], v[0]));
      end
`endif
    end
    start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_idle: got busy=%b, required 0", busy2);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_abort();
    test_back_to_back_w2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
